mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single external memory port between I-cache refills (read-only) and D-cache refills/writebacks.
//  Per line transfer: one request beat, then BEATS data beats; grants alternate round-robin, so neither side starves.
//  Sits between icache/dcache miss logic and the memory interface, outside the 3-stage Riscv151 pipeline.
// PARAMETERS
//  ADDR_W  28   line address width (byte address >> log2(line bytes))
//  DATA_W  128  beat width
//  BEATS   4    beats per cache line; power of two, >= 2
// PORTS
//  clk             in   1       clock; all state updates on rising edge
//  reset           in   1       asynchronous, active-low reset (0 = reset)
//  ic_req_valid    in   1       I-side refill request
//  ic_req_ready    out  1       I-side request accepted (combinational, IDLE only)
//  ic_req_addr     in   ADDR_W  I-side line address
//  ic_resp_valid   out  1       I-side refill beat valid (registered)
//  ic_resp_data    out  DATA_W  I-side refill beat
//  ic_resp_last    out  1       final beat of the I-side line
//  dc_req_valid    in   1       D-side request
//  dc_req_ready    out  1       D-side request accepted (combinational, IDLE only)
//  dc_req_addr     in   ADDR_W  D-side line address
//  dc_req_rnw      in   1       1 = refill read, 0 = writeback
//  dc_wdata_valid  in   1       writeback beat valid
//  dc_wdata_ready  out  1       writeback beat accepted
//  dc_wdata        in   DATA_W  writeback beat
//  dc_resp_valid   out  1       D-side refill beat valid (registered)
//  dc_resp_data    out  DATA_W  D-side refill beat
//  dc_resp_last    out  1       final beat of the D-side line
//  mem_req_valid   out  1       memory command valid
//  mem_req_ready   in   1       memory command accepted
//  mem_req_addr    out  ADDR_W  memory command address (latched at grant)
//  mem_req_rnw     out  1       memory command type
//  mem_wdata_valid out  1       memory write beat valid
//  mem_wdata_ready in   1       memory write beat accepted
//  mem_wdata       out  DATA_W  memory write beat
//  mem_resp_valid  in   1       memory read beat valid (no backpressure)
//  mem_resp_data   in   DATA_W  memory read beat
//  owner_d         out  1       1 = current or last grant is D-side
//  busy            out  1       state != IDLE
//  proto_err       out  1       sticky: mem_resp_valid outside RD_DATA
// BEHAVIOUR
//  Reset: state = IDLE, beat counter = 0, last_grant = I (D wins the first tie).
//   Every output resets to 0; all data outputs reset to 0.
//  FSM: IDLE -> CMD -> RD_DATA | WR_DATA -> IDLE.
//  IDLE, grant: winner = requester with valid high. If both are high, winner = side != last_grant.
//   Only the winner's req_ready = 1 in the same cycle. Handshake = valid & ready.
//   On handshake: latch addr and rnw (I-side rnw = 1); update last_grant and owner_d; go to CMD.
//  CMD: mem_req_valid = 1; addr/rnw held stable until mem_req_ready.
//   On mem_req_valid & mem_req_ready: go to RD_DATA if rnw, else WR_DATA. Counter = 0.
//  RD_DATA: each mem_resp_valid is registered to the owner's resp_valid/resp_data one cycle later.
//   resp_last = 1 on beat BEATS-1. The non-owner's resp_valid stays 0. Counter increments per beat.
//   On beat BEATS-1: go to IDLE. The IDLE cycle may grant while the last beat is still on resp outputs.
//  WR_DATA: combinational pass-through.
//   mem_wdata_valid = dc_wdata_valid; dc_wdata_ready = mem_wdata_ready; mem_wdata = dc_wdata.
//   Count handshakes. On handshake BEATS-1: go to IDLE. No response beat is returned for writes.
//   Outside WR_DATA, mem_wdata_valid = dc_wdata_ready = 0.
//  Counter is log2(BEATS) bits; wraps to 0 on the last beat.
//  mem_resp_valid in IDLE/CMD/WR_DATA: beat is dropped and proto_err is set; proto_err clears only on reset.
//  Requests during a transfer are not accepted (both req_ready = 0) and must be held by requesters.
//  Reset mid-transfer: immediate return to IDLE with all outputs 0. Memory shares the same reset.
// TESTING
//  T1 I read: ic_req addr 0x100, mem_req_ready=1, 4 resp beats A..D -> mem_req addr 0x100 rnw=1;
//     ic_resp A..D each +1 cycle, last on D; dc_resp_valid stays 0.
//  T2 D writeback: addr 0x2A, rnw=0, beats W0..W3, mem_wdata_ready toggling 1,0,1 -> exactly 4 mem_wdata handshakes in order;
//     IDLE the cycle after the 4th.
//  T3 Contention: both valid every cycle after reset -> grants D,I,D,I; owner_d = 1,0,1,0.
//  T4 Command stall: mem_req_ready=0 for 5 cycles -> mem_req_valid/addr stable for 5 cycles; both req_ready stay 0.
//  T5 Stray beat: mem_resp_valid in IDLE -> proto_err=1, no resp_valid; proto_err stays 1 until reset.
//  T6 Reset mid-read: reset=0 after beat 2 -> all outputs 0 immediately; a fresh read then completes with 4 beats.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between I-cache refills and
// D-cache refills/writebacks: one command beat followed by BEATS data beats.
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128,
    parameter int BEATS  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_req_valid,
    output logic              ic_req_ready,
    input  logic [ADDR_W-1:0] ic_req_addr,
    output logic              ic_resp_valid,
    output logic [DATA_W-1:0] ic_resp_data,
    output logic              ic_resp_last,
    input  logic              dc_req_valid,
    output logic              dc_req_ready,
    input  logic [ADDR_W-1:0] dc_req_addr,
    input  logic              dc_req_rnw,
    input  logic              dc_wdata_valid,
    output logic              dc_wdata_ready,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic              dc_resp_valid,
    output logic [DATA_W-1:0] dc_resp_data,
    output logic              dc_resp_last,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_rnw,
    output logic              mem_wdata_valid,
    input  logic              mem_wdata_ready,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data,
    output logic              owner_d,
    output logic              busy,
    output logic              proto_err
);

    localparam int CNT_W = $clog2(BEATS);

    typedef enum logic [1:0] {IDLE, CMD, RD_DATA, WR_DATA} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               last_grant_d;
    logic               owner_q;
    logic               rnw_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               ic_rv_q, dc_rv_q, last_q;
    logic [DATA_W-1:0]  rdata_q;
    logic               perr_q;

    logic winner_d, grant, in_wr, wr_hs, rd_beat, cnt_last;

    // On a tie the side that did not win last time is chosen.
    assign winner_d = (ic_req_valid && dc_req_valid) ? !last_grant_d : dc_req_valid;
    // Gated with reset so no request is ever acknowledged while reset is held.
    assign grant    = (state == IDLE) && reset && (ic_req_valid || dc_req_valid);
    assign in_wr    = (state == WR_DATA);
    assign wr_hs    = in_wr && dc_wdata_valid && mem_wdata_ready;
    assign rd_beat  = (state == RD_DATA) && mem_resp_valid;
    assign cnt_last = (cnt == CNT_W'(BEATS - 1));

    assign ic_req_ready    = grant && !winner_d;
    assign dc_req_ready    = grant && winner_d;
    assign mem_req_valid   = (state == CMD);
    assign mem_req_addr    = addr_q;
    assign mem_req_rnw     = rnw_q;
    assign mem_wdata_valid = in_wr && dc_wdata_valid;
    assign dc_wdata_ready  = in_wr && mem_wdata_ready;
    assign mem_wdata       = in_wr ? dc_wdata : '0;
    assign ic_resp_valid   = ic_rv_q;
    assign dc_resp_valid   = dc_rv_q;
    assign ic_resp_data    = rdata_q;
    assign dc_resp_data    = rdata_q;
    assign ic_resp_last    = ic_rv_q && last_q;
    assign dc_resp_last    = dc_rv_q && last_q;
    assign owner_d         = owner_q;
    assign busy            = (state != IDLE);
    assign proto_err       = perr_q;

    // NOTE: next state gets a default before the case so no path infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = CMD;
            CMD:     if (mem_req_ready) state_nxt = rnw_q ? RD_DATA : WR_DATA;
            RD_DATA: if (rd_beat && cnt_last) state_nxt = IDLE;
            WR_DATA: if (wr_hs && cnt_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt          <= '0;
            last_grant_d <= 1'b0;
            owner_q      <= 1'b0;
            rnw_q        <= 1'b0;
            addr_q       <= '0;
            ic_rv_q      <= 1'b0;
            dc_rv_q      <= 1'b0;
            last_q       <= 1'b0;
            rdata_q      <= '0;
            perr_q       <= 1'b0;
        end else begin
            if (grant) begin
                last_grant_d <= winner_d;
                owner_q      <= winner_d;
                addr_q       <= winner_d ? dc_req_addr : ic_req_addr;
                rnw_q        <= winner_d ? dc_req_rnw : 1'b1;
            end

            if (state == CMD && mem_req_ready) begin
                cnt <= '0;
            end else if (rd_beat || wr_hs) begin
                cnt <= cnt + CNT_W'(1);
            end

            ic_rv_q <= rd_beat && !owner_q;
            dc_rv_q <= rd_beat && owner_q;
            if (rd_beat) begin
                rdata_q <= mem_resp_data;
                last_q  <= cnt_last;
            end

            // A read beat arriving when no read is in flight is discarded.
            if (mem_resp_valid && state != RD_DATA) begin
                perr_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table of grant sequences, directed
// corner cases, and randomized transfers against a round-robin reference model.
module tb_mem_arbiter;

    localparam int ADDR_W = 28;
    localparam int DATA_W = 128;
    localparam int BEATS  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              ic_req_valid, ic_req_ready;
    logic [ADDR_W-1:0] ic_req_addr;
    logic              ic_resp_valid, ic_resp_last;
    logic [DATA_W-1:0] ic_resp_data;
    logic              dc_req_valid, dc_req_ready, dc_req_rnw;
    logic [ADDR_W-1:0] dc_req_addr;
    logic              dc_wdata_valid, dc_wdata_ready;
    logic [DATA_W-1:0] dc_wdata;
    logic              dc_resp_valid, dc_resp_last;
    logic [DATA_W-1:0] dc_resp_data;
    logic              mem_req_valid, mem_req_ready, mem_req_rnw;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_wdata_valid, mem_wdata_ready;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_data;
    logic              owner_d, busy, proto_err;

    int n_vec = 0;
    int n_err = 0;
    bit last_m = 1'b0;   // reference model: 1 = last grant went to D

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS)) dut (
        .clk(clk), .reset(reset),
        .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
        .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data), .ic_resp_last(ic_resp_last),
        .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_addr(dc_req_addr),
        .dc_req_rnw(dc_req_rnw), .dc_wdata_valid(dc_wdata_valid), .dc_wdata_ready(dc_wdata_ready),
        .dc_wdata(dc_wdata), .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
        .dc_resp_last(dc_resp_last), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_rnw(mem_req_rnw), .mem_wdata_valid(mem_wdata_valid),
        .mem_wdata_ready(mem_wdata_ready), .mem_wdata(mem_wdata), .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data), .owner_d(owner_d), .busy(busy), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit              ic_v;
        bit              dc_v;
        bit              dc_rnw;
        logic [ADDR_W-1:0] ic_addr;
        logic [ADDR_W-1:0] dc_addr;
        bit              exp_d;
    } vec_t;

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] rnd_data();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic bit model_winner(input bit icv, input bit dcv);
        return (icv && dcv) ? !last_m : dcv;
    endfunction

    // Presents requests in IDLE, checks who is acknowledged, then clocks the grant.
    task automatic grant(input bit icv, input bit dcv, input bit rnw,
                         input logic [ADDR_W-1:0] ia, input logic [ADDR_W-1:0] da, input bit exp_d);
        ic_req_valid = icv;
        dc_req_valid = dcv;
        dc_req_rnw   = rnw;
        ic_req_addr  = ia;
        dc_req_addr  = da;
        #1;
        check("idle_busy", busy, 0);
        check("ic_req_ready", ic_req_ready, icv && !exp_d);
        check("dc_req_ready", dc_req_ready, dcv && exp_d);
        tick();
        last_m = exp_d;
    endtask

    // Entered one cycle after the grant edge (state CMD); finishes back in IDLE.
    task automatic run_xfer(input bit exp_d, input bit rnw, input logic [ADDR_W-1:0] addr,
                            input int stall, input bit gaps, input int wmode, input bit hold);
        logic [DATA_W-1:0] wbeat [BEATS];
        logic [DATA_W-1:0] d;
        int idx, cyc;
        bit hs;
        check("owner_d", owner_d, exp_d);
        check("cmd_busy", busy, 1);
        check("cmd_valid", mem_req_valid, 1);
        check("cmd_addr", mem_req_addr, addr);
        check("cmd_rnw", mem_req_rnw, rnw);
        check("cmd_ic_ready", ic_req_ready, 0);
        check("cmd_dc_ready", dc_req_ready, 0);
        for (int s = 0; s < stall; s++) begin
            mem_req_ready = 1'b0;
            tick();
            check("stall_valid", mem_req_valid, 1);
            check("stall_addr", mem_req_addr, addr);
            check("stall_ic_ready", ic_req_ready, 0);
            check("stall_dc_ready", dc_req_ready, 0);
        end
        if (!hold) begin
            ic_req_valid = 1'b0;
            dc_req_valid = 1'b0;
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        check("cmd_done", mem_req_valid, 0);
        if (rnw) begin
            for (int b = 0; b < BEATS; b++) begin
                if (gaps && $urandom_range(0, 1) == 1) begin
                    mem_resp_valid = 1'b0;
                    tick();
                    check("gap_valid", exp_d ? dc_resp_valid : ic_resp_valid, 0);
                end
                d = rnd_data();
                mem_resp_valid = 1'b1;
                mem_resp_data  = d;
                tick();
                mem_resp_valid = 1'b0;
                check("resp_valid", exp_d ? dc_resp_valid : ic_resp_valid, 1);
                check("resp_other", exp_d ? ic_resp_valid : dc_resp_valid, 0);
                check("resp_data", exp_d ? dc_resp_data : ic_resp_data, d);
                check("resp_last", exp_d ? dc_resp_last : ic_resp_last, b == BEATS - 1);
            end
        end else begin
            for (int b = 0; b < BEATS; b++) wbeat[b] = rnd_data();
            idx = 0;
            cyc = 0;
            while (idx < BEATS && cyc < 200) begin
                dc_wdata_valid  = (wmode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
                mem_wdata_ready = (wmode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
                dc_wdata        = wbeat[idx];
                #1;
                check("wr_valid", mem_wdata_valid, dc_wdata_valid);
                check("wr_ready", dc_wdata_ready, mem_wdata_ready);
                check("wr_data", mem_wdata, wbeat[idx]);
                hs = dc_wdata_valid && mem_wdata_ready;
                tick();
                if (hs) idx++;
                cyc++;
            end
            check("wr_beats_done", idx, BEATS);
            dc_wdata_valid  = 1'b0;
            mem_wdata_ready = 1'b0;
            #1;
            check("wr_idle_valid", mem_wdata_valid, 0);
            check("wr_no_resp", ic_resp_valid | dc_resp_valid, 0);
        end
        check("xfer_idle", busy, 0);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        #3;
        reset = 1'b1;
        last_m = 1'b0;
    endtask

    vec_t tbl [8];
    bit icv, dcv, rnw, w;
    logic [ADDR_W-1:0] ia, da;
    logic [DATA_W-1:0] d;

    initial begin
        tbl[0] = '{1, 0, 1, 28'h0000100, 28'h0, 0};   // I alone
        tbl[1] = '{1, 1, 1, 28'h0000200, 28'h0000300, 1}; // tie after I -> D
        tbl[2] = '{1, 1, 0, 28'h0000400, 28'h0000500, 0}; // tie after D -> I
        tbl[3] = '{0, 1, 0, 28'h0, 28'h000002A, 1};   // D writeback alone
        tbl[4] = '{0, 1, 1, 28'h0, 28'h0000600, 1};   // D read alone
        tbl[5] = '{1, 1, 1, 28'h0000700, 28'h0000800, 0}; // tie after D -> I
        tbl[6] = '{1, 0, 1, 28'h0000900, 28'h0, 0};
        tbl[7] = '{1, 1, 0, 28'h0000A00, 28'h0000B00, 1}; // tie after I -> D

        reset = 1'b0;
        ic_req_valid = 0; ic_req_addr = '0;
        dc_req_valid = 0; dc_req_addr = '0; dc_req_rnw = 0;
        dc_wdata_valid = 0; dc_wdata = '0;
        mem_req_ready = 0; mem_wdata_ready = 0;
        mem_resp_valid = 0; mem_resp_data = '0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_owner", owner_d, 0);
        check("rst_proto", proto_err, 0);
        check("rst_req_valid", mem_req_valid, 0);
        check("rst_req_addr", mem_req_addr, 0);
        check("rst_req_rnw", mem_req_rnw, 0);
        check("rst_wdata_valid", mem_wdata_valid, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_resp", {ic_resp_valid, dc_resp_valid, ic_resp_last, dc_resp_last}, 0);
        check("rst_resp_data", ic_resp_data | dc_resp_data, 0);
        ic_req_valid = 1'b1;
        #1;
        check("rst_no_ready", ic_req_ready, 0);
        ic_req_valid = 1'b0;
        reset = 1'b1;
        tick();

        // T1: I-side read at 0x100
        grant(1, 0, 1, 28'h100, 28'h0, 1'b0);
        run_xfer(1'b0, 1'b1, 28'h100, 0, 0, 0, 0);

        // T2: D writeback at 0x2A with memory ready toggling
        grant(0, 1, 0, 28'h0, 28'h2A, 1'b1);
        run_xfer(1'b1, 1'b0, 28'h2A, 0, 0, 1, 0);

        // Table of grant sequences from reset
        apply_reset();
        tick();
        for (int i = 0; i < 8; i++) begin
            grant(tbl[i].ic_v, tbl[i].dc_v, tbl[i].dc_rnw, tbl[i].ic_addr, tbl[i].dc_addr, tbl[i].exp_d);
            run_xfer(tbl[i].exp_d, tbl[i].exp_d ? tbl[i].dc_rnw : 1'b1,
                     tbl[i].exp_d ? tbl[i].dc_addr : tbl[i].ic_addr, 0, 0, 0, 0);
        end

        // T3: both sides requesting continuously after reset -> D, I, D, I
        apply_reset();
        tick();
        for (int k = 0; k < 4; k++) begin
            w = (k % 2 == 0);
            grant(1, 1, 1, 28'h111, 28'h222, w);
            run_xfer(w, 1'b1, w ? 28'h222 : 28'h111, 0, 0, 0, 1);
        end
        ic_req_valid = 1'b0;
        dc_req_valid = 1'b0;

        // T4: command stalled 5 cycles while both sides keep requesting
        grant(1, 1, 1, 28'h333, 28'h444, model_winner(1, 1));
        run_xfer(last_m, 1'b1, last_m ? 28'h444 : 28'h333, 5, 0, 0, 0);

        // Randomized transfers against the round-robin model
        for (int r = 0; r < 30; r++) begin
            icv = 1'($urandom_range(0, 1));
            dcv = icv ? 1'($urandom_range(0, 1)) : 1'b1;
            rnw = 1'($urandom_range(0, 1));
            ia  = ADDR_W'($urandom());
            da  = ADDR_W'($urandom());
            w   = model_winner(icv, dcv);
            grant(icv, dcv, rnw, ia, da, w);
            run_xfer(w, w ? rnw : 1'b1, w ? da : ia, $urandom_range(0, 3), 1, 0, 0);
        end
        check("rand_proto", proto_err, 0);

        // T5: stray read beat in IDLE is dropped and latches proto_err
        mem_resp_valid = 1'b1;
        mem_resp_data  = rnd_data();
        tick();
        mem_resp_valid = 1'b0;
        check("stray_proto", proto_err, 1);
        check("stray_resp", ic_resp_valid | dc_resp_valid, 0);
        grant(1, 0, 1, 28'h555, 28'h0, 1'b0);
        run_xfer(1'b0, 1'b1, 28'h555, 0, 0, 0, 0);
        tick();
        check("stray_sticky", proto_err, 1);

        // T6: reset in the middle of a D-side read, then a fresh read
        grant(0, 1, 1, 28'h0, 28'h666, 1'b1);
        dc_req_valid  = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            d = rnd_data();
            mem_resp_valid = 1'b1;
            mem_resp_data  = d;
            tick();
            mem_resp_valid = 1'b0;
        end
        check("mid_resp_valid", dc_resp_valid, 1);
        reset = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_owner", owner_d, 0);
        check("mid_rst_resp", dc_resp_valid | ic_resp_valid, 0);
        check("mid_rst_data", dc_resp_data, 0);
        check("mid_rst_proto", proto_err, 0);
        check("mid_rst_req", mem_req_valid, 0);
        #2;
        reset = 1'b1;
        last_m = 1'b0;
        tick();
        grant(1, 1, 1, 28'h777, 28'h888, model_winner(1, 1));
        run_xfer(1'b1, 1'b1, 28'h888, 0, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
